// File: rtl/t03_mmio_router.sv
// MMIO router: registers each CPU access and runs it to one peripheral channel
// or to Wishbone RAM. Each access ends in a one-cycle ack, and a timeout bounds every wait.
module t03_mmio_router #(
  parameter int          NPERIPH   = 4,
  parameter logic [31:0] MMIO_BASE = 32'hFF000000,
  parameter int          TIMEOUT   = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          cpu_addr,
  input  logic [31:0]          cpu_din,
  input  logic                 cpu_wen,
  input  logic                 cpu_ren,
  output logic [31:0]          cpu_do,
  output logic                 cpu_ack,
  output logic                 cpu_err,
  output logic [NPERIPH-1:0]   pr_req,
  output logic                 pr_wen,
  output logic [31:0]          pr_do,
  input  logic [32*NPERIPH-1:0] pr_din,
  input  logic [NPERIPH-1:0]   pr_ack,
  output logic [31:0]          wb_addro,
  output logic [31:0]          wb_do,
  output logic [3:0]           wb_sel,
  output logic                 wb_wen,
  output logic                 wb_ren,
  input  logic [31:0]          wb_di,
  input  logic                 wb_ack
);

  localparam int              IW   = (NPERIPH > 1) ? $clog2(NPERIPH) : 1;
  localparam logic [NPERIPH-1:0] REQ0 = NPERIPH'(1);
  localparam logic [7:0]      TMO  = 8'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, PERIPH, WB, RESP} state_t;

  state_t        state;
  logic          we;
  logic [IW-1:0] idx;
  logic [7:0]    cnt;

  logic        req_any, in_window, slot_ok, timed_out, sel_ack;
  logic [31:0] sel_din;

  assign req_any   = cpu_ren | cpu_wen;
  assign in_window = (cpu_addr[31:8] == MMIO_BASE[31:8]);
  assign slot_ok   = ({26'd0, cpu_addr[7:2]} < 32'(NPERIPH));
  assign timed_out = (cnt == TMO);
  assign sel_ack   = pr_ack[idx];
  assign sel_din   = pr_din[{idx, 5'd0} +: 32];
  assign wb_sel    = 4'b1111;

  // Outputs are registered from the next state, so every strobe change and the
  // ack pulse are made here alongside the state transition.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: every register here is plain state (no memory array), so all of it is
    // reset; an async reset also aborts any transaction in flight.
    if (rst) begin
      state    <= IDLE;
      we       <= 1'b0;
      idx      <= '0;
      cnt      <= '0;
      cpu_do   <= '0;
      cpu_ack  <= 1'b0;
      cpu_err  <= 1'b0;
      pr_req   <= '0;
      pr_wen   <= 1'b0;
      pr_do    <= '0;
      wb_addro <= '0;
      wb_do    <= '0;
      wb_wen   <= 1'b0;
      wb_ren   <= 1'b0;
    end else begin
      // NOTE: non-blocking throughout, so every branch sees the pre-edge state;
      // the pulse defaults below are overridden only on entry to RESP.
      cpu_ack <= 1'b0;
      cpu_err <= 1'b0;
      case (state)
        IDLE: begin
          if (req_any) begin
            we  <= cpu_wen;
            cnt <= '0;
            if (in_window && slot_ok) begin
              state  <= PERIPH;
              idx    <= cpu_addr[2 +: IW];
              pr_req <= REQ0 << cpu_addr[2 +: IW];
              pr_wen <= cpu_wen;
              pr_do  <= cpu_din;
            end else if (in_window) begin
              // Unmapped slot inside the window: fail without touching any bus.
              state   <= RESP;
              cpu_ack <= 1'b1;
              cpu_err <= 1'b1;
            end else begin
              state    <= WB;
              wb_addro <= cpu_addr;
              wb_do    <= cpu_din;
              wb_wen   <= cpu_wen;
              wb_ren   <= ~cpu_wen;
            end
          end
        end

        PERIPH: begin
          if (sel_ack || timed_out) begin
            state   <= RESP;
            pr_req  <= '0;
            pr_wen  <= 1'b0;
            cpu_ack <= 1'b1;
            if (sel_ack) cpu_do <= we ? 32'd0 : sel_din;
            else begin
              cpu_do  <= 32'hFFFFFFFF;
              cpu_err <= 1'b1;
            end
          end else begin
            cnt <= cnt + 8'd1;
          end
        end

        WB: begin
          if (wb_ack || timed_out) begin
            state   <= RESP;
            wb_wen  <= 1'b0;
            wb_ren  <= 1'b0;
            cpu_ack <= 1'b1;
            if (wb_ack) cpu_do <= we ? 32'd0 : wb_di;
            else begin
              cpu_do  <= 32'hFFFFFFFF;
              cpu_err <= 1'b1;
            end
          end else begin
            cnt <= cnt + 8'd1;
          end
        end

        RESP: state <= IDLE;

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_t03_mmio_router.sv
// Randomised scoreboard bench for t03_mmio_router: the stimulus side queues the
// expected response of each access; a monitor checks every cpu_ack against it.
module tb_t03_mmio_router;

  localparam int NP  = 4;
  localparam int TMO = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic [31:0]       cpu_addr, cpu_din, cpu_do;
  logic              cpu_wen, cpu_ren, cpu_ack, cpu_err;
  logic [NP-1:0]     pr_req, pr_ack;
  logic              pr_wen;
  logic [31:0]       pr_do;
  logic [32*NP-1:0]  pr_din;
  logic [31:0]       wb_addro, wb_do, wb_di;
  logic [3:0]        wb_sel;
  logic              wb_wen, wb_ren, wb_ack;

  t03_mmio_router #(.NPERIPH(NP), .MMIO_BASE(32'hFF000000), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .cpu_addr(cpu_addr), .cpu_din(cpu_din), .cpu_wen(cpu_wen), .cpu_ren(cpu_ren),
    .cpu_do(cpu_do), .cpu_ack(cpu_ack), .cpu_err(cpu_err),
    .pr_req(pr_req), .pr_wen(pr_wen), .pr_do(pr_do), .pr_din(pr_din), .pr_ack(pr_ack),
    .wb_addro(wb_addro), .wb_do(wb_do), .wb_sel(wb_sel), .wb_wen(wb_wen),
    .wb_ren(wb_ren), .wb_di(wb_di), .wb_ack(wb_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] do_v;
    logic        err;
    int          lat;
    int          c0;
  } exp_t;

  exp_t        sb[$];
  int          cyc = 0;
  int          tests = 0;
  int          fails = 0;
  logic [31:0] last_do = 32'd0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every ack must match the oldest outstanding expectation.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst && cpu_ack) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_ack: got ack with no access outstanding (cycle %0d)", cyc);
      end else begin
        e = sb.pop_front();
        check("cpu_do", cpu_do, e.do_v);
        check("cpu_err", cpu_err, e.err);
        check("ack_latency", cyc - e.c0, e.lat);
      end
    end
  end

  task automatic idle(input int n);
    @(posedge clk); #1;
    cpu_ren = 1'b0;
    cpu_wen = 1'b0;
    pr_ack  = '0;
    wb_ack  = 1'b0;
    repeat (n - 1) @(posedge clk);
  endtask

  // One CPU access; delay is the cycle (>=1) in which the target acks.
  task automatic do_txn(input logic [31:0] addr, input logic [31:0] din, input logic wen,
                        input logic ren, input int delay, input logic [31:0] rdata);
    bit   mmio, periph, act;
    int   slot, fin;
    exp_t e;
    logic [NP-1:0] onehot;
    mmio   = (addr[31:8] == 24'hFF0000);
    slot   = int'(addr[7:2]);
    periph = mmio && (slot < NP);
    onehot = periph ? NP'(1 << slot) : '0;
    // Reference rules: unmapped fails at once, an ack by cycle TMO+1 wins, else timeout.
    if (mmio && !periph) begin
      fin = 0; e.do_v = last_do; e.err = 1'b1;
    end else if (delay <= TMO + 1) begin
      fin = delay; e.do_v = wen ? 32'd0 : rdata; e.err = 1'b0;
    end else begin
      fin = TMO + 1; e.do_v = 32'hFFFFFFFF; e.err = 1'b1;
    end
    e.lat   = fin + 1;
    last_do = e.do_v;

    @(posedge clk); #1;
    cpu_addr = addr;
    cpu_din  = din;
    cpu_wen  = wen;
    cpu_ren  = ren;
    pr_ack   = '0;
    wb_ack   = 1'b0;
    e.c0     = cyc;
    sb.push_back(e);

    for (int k = 1; k <= fin + 1; k++) begin
      @(posedge clk); #1;
      act = (k <= fin);
      check("pr_req", pr_req, act ? onehot : '0);
      check("pr_wen", pr_wen, (periph && act) ? wen : 1'b0);
      check("wb_ren", wb_ren, (!mmio && act && !wen) ? 1'b1 : 1'b0);
      check("wb_wen", wb_wen, (!mmio && act && wen) ? 1'b1 : 1'b0);
      if (k == 1 && periph) check("pr_do", pr_do, din);
      if (k == 1 && !mmio) begin
        check("wb_addro", wb_addro, addr);
        check("wb_do", wb_do, din);
      end
      // Noise on channels that must be ignored, then the real ack if due.
      pr_din = {$urandom, $urandom, $urandom, $urandom};
      wb_di  = $urandom;
      pr_ack = NP'($urandom) & ~onehot;
      wb_ack = periph ? 1'($urandom) : 1'b0;
      if (k == delay && act) begin
        if (periph) begin
          pr_ack[slot] = 1'b1;
          pr_din[slot*32 +: 32] = rdata;
        end else begin
          wb_ack = 1'b1;
          wb_di  = rdata;
        end
      end
    end
  endtask

  initial begin
    logic [31:0] a;
    int          sel;
    rst = 1'b1;
    cpu_addr = '0; cpu_din = '0; cpu_wen = 1'b0; cpu_ren = 1'b0;
    pr_din = '0; pr_ack = '0; wb_di = '0; wb_ack = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_cpu_ack", cpu_ack, 1'b0);
    check("rst_cpu_err", cpu_err, 1'b0);
    check("rst_cpu_do", cpu_do, 32'd0);
    check("rst_pr_req", pr_req, '0);
    check("rst_wb_ren", wb_ren, 1'b0);
    check("rst_wb_wen", wb_wen, 1'b0);
    check("rst_wb_addro", wb_addro, 32'd0);
    check("rst_wb_sel", wb_sel, 4'b1111);
    @(posedge clk); #1;
    rst = 1'b0;
    idle(2);

    // Directed cases.
    do_txn(32'hFF000000, 32'h0, 1'b0, 1'b1, 1, 32'h000000A5);
    do_txn(32'hFF000004, 32'h00003ACF, 1'b1, 1'b0, 3, 32'hDEAD0000);
    do_txn(32'h00001000, 32'h0, 1'b0, 1'b1, 5, 32'hCAFEF00D);
    do_txn(32'hFF000040, 32'h0, 1'b0, 1'b1, 1, 32'h11111111);
    do_txn(32'hFF00000C, 32'h0, 1'b0, 1'b1, 50, 32'h22222222);
    do_txn(32'hFF00000C, 32'h0, 1'b0, 1'b1, TMO + 1, 32'h12345678);
    do_txn(32'h00002000, 32'h55AA55AA, 1'b1, 1'b1, TMO + 1, 32'h33333333);
    do_txn(32'h00003000, 32'h0, 1'b0, 1'b1, TMO + 2, 32'h44444444);
    idle(2);

    // Reset during a Wishbone wait aborts it with no ack.
    @(posedge clk); #1;
    cpu_addr = 32'h00002000; cpu_ren = 1'b1; cpu_wen = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    check("pre_rst_wb_ren", wb_ren, 1'b1);
    rst = 1'b1;
    #1;
    check("abort_wb_ren", wb_ren, 1'b0);
    check("abort_cpu_ack", cpu_ack, 1'b0);
    check("abort_cpu_do", cpu_do, 32'd0);
    last_do  = 32'd0;
    cpu_ren  = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (TMO + 4) @(posedge clk);
    do_txn(32'h00004000, 32'h0, 1'b0, 1'b1, 2, 32'h0BADBEEF);

    // Randomised traffic, mixing back-to-back and gapped accesses.
    for (int n = 0; n < 250; n++) begin
      case ($urandom_range(0, 2))
        0:       a = {24'hFF0000, 6'($urandom_range(0, NP - 1)), 2'($urandom)};
        1:       a = {24'hFF0000, 6'($urandom), 2'($urandom)};
        default: begin
          a = $urandom;
          if (a[31:8] == 24'hFF0000) a[31] = 1'b0;
        end
      endcase
      sel = $urandom_range(0, 2);
      do_txn(a, $urandom, (sel != 0), (sel != 1), $urandom_range(1, TMO + 3), $urandom);
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
    end

    idle(4);
    check("scoreboard_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
